// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-transfer master: queued word commands issued as NONSEQ SINGLE
// transfers with overlapped address/data phases and a one-cycle response strobe.
module ahb_lite_cmd_master #(
  parameter int CMD_DEPTH = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(CMD_DEPTH);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic {ST_NORMAL, ST_CANCEL} state_e;

  state_e            state_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              fifo_write_q [CMD_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [CMD_DEPTH];
  logic [DATA_W-1:0] fifo_wdata_q [CMD_DEPTH];
  logic              dp_valid_q, dp_write_q;
  logic [DATA_W-1:0] dp_wdata_q;
  logic              rsp_valid_q, rsp_write_q, rsp_error_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              push, issue, pop, done;

  assign cmd_ready = (count_q != FULL);
  assign push      = cmd_valid & cmd_ready;
  assign issue     = (count_q != '0) & (state_q == ST_NORMAL);
  assign pop       = issue & HREADY;
  assign done      = dp_valid_q & HREADY;

  assign HTRANS = issue ? TR_NONSEQ : TR_IDLE;
  assign HADDR  = issue ? fifo_addr_q[rd_ptr_q] : '0;
  assign HWRITE = issue & fifo_write_q[rd_ptr_q];
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign HWDATA = dp_wdata_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign busy      = (count_q != '0) | dp_valid_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Storage is not reset: the pointers alone define which entries are live.
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= cmd_write;
      fifo_addr_q[wr_ptr_q]  <= cmd_addr & ~ADDR_W'(3);
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // A new address accepted on the completing edge keeps the data phase occupied.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_wdata_q <= '0;
    end else if (pop) begin
      dp_valid_q <= 1'b1;
      dp_write_q <= fifo_write_q[rd_ptr_q];
      dp_wdata_q <= fifo_wdata_q[rd_ptr_q];
    end else if (done) begin
      dp_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= done;
      rsp_write_q <= done & dp_write_q;
      rsp_rdata_q <= (done && !dp_write_q) ? HRDATA : '0;
      rsp_error_q <= done & HRESP;
    end
  end

  // Two-cycle ERROR: idle the address phase until the slave finishes the error.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_NORMAL;
    end else begin
      case (state_q)
        ST_NORMAL: if (dp_valid_q && HRESP && !HREADY) state_q <= ST_CANCEL;
        ST_CANCEL: if (HREADY) state_q <= ST_NORMAL;
        default:   state_q <= ST_NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master: directed scenarios plus a randomized run, all
// checked every cycle against a transaction-level queue model and slave memory.
module tb_ahb_lite_cmd_master;

  localparam int DEPTH = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_write, rsp_error, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA;
  logic [31:0] HRDATA = '0;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY = 1'b1, HRESP = 1'b0;
  logic [2:0]  HSIZE, HBURST;

  ahb_lite_cmd_master #(.CMD_DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Model state: queued commands, the transfer in its data phase, cancel window.
  cmd_t        pend[$];
  bit          m_dp, m_dp_write, m_cancel;
  logic [31:0] m_dp_addr, m_dp_wdata;
  bit          rsp_due, r_write, r_err;
  logic [31:0] r_rdata;
  logic [31:0] mem [logic [31:0]];
  int          n_total = 0, n_pass = 0, n_fail = 0, n_rsp = 0;
  logic [31:0] last_rdata;
  bit          sl_started, sl_err;
  int          sl_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic model_reset();
    pend.delete();
    m_dp = 0; m_cancel = 0; rsp_due = 0; sl_started = 0;
  endtask

  // One bus cycle: check outputs at the negedge, drive inputs, advance the model.
  task automatic cycle(input bit cv, input bit cw, input logic [31:0] ca,
                       input logic [31:0] cd, input bit hr, input bit hs);
    logic [1:0] exp_trans;
    bit rdy, acc, done, push;
    cmd_t c;
    exp_trans = (pend.size() != 0 && !m_cancel) ? 2'b10 : 2'b00;
    rdy = pend.size() < DEPTH;
    chk("HTRANS", 32'(HTRANS), 32'(exp_trans));
    if (exp_trans == 2'b10) begin
      chk("HADDR", HADDR, pend[0].addr);
      chk("HWRITE", 32'(HWRITE), 32'(pend[0].write));
    end
    chk("cmd_ready", 32'(cmd_ready), 32'(rdy));
    chk("busy", 32'(busy), 32'(pend.size() != 0 || m_dp));
    if (m_dp && m_dp_write) chk("HWDATA", HWDATA, m_dp_wdata);
    chk("rsp_valid", 32'(rsp_valid), 32'(rsp_due));
    if (rsp_due) begin
      chk("rsp_write", 32'(rsp_write), 32'(r_write));
      chk("rsp_rdata", rsp_rdata, r_rdata);
      chk("rsp_error", 32'(rsp_error), 32'(r_err));
    end
    if (rsp_valid === 1'b1) begin
      n_rsp++;
      last_rdata = rsp_rdata;
    end
    cmd_valid = cv; cmd_write = cw; cmd_addr = ca; cmd_wdata = cd;
    HREADY = hr; HRESP = hs;
    HRDATA = (m_dp && !m_dp_write) ? rd_val(m_dp_addr) : 32'hDEAD_0000 ^ $urandom_range(0, 255);
    done = m_dp && hr;
    acc  = (exp_trans == 2'b10) && hr;
    push = cv && rdy;
    rsp_due = done;
    if (done) begin
      r_write = m_dp_write;
      r_err   = hs;
      r_rdata = m_dp_write ? 32'h0 : HRDATA;
      if (m_dp_write && !hs) mem[m_dp_addr] = m_dp_wdata;
    end
    if (!m_cancel && m_dp && hs && !hr) m_cancel = 1;
    else if (m_cancel && hr) m_cancel = 0;
    if (acc) begin
      c = pend.pop_front();
      m_dp = 1; m_dp_write = c.write; m_dp_addr = c.addr; m_dp_wdata = c.wdata;
    end else if (done) begin
      m_dp = 0;
    end
    if (push) begin
      c.write = cw; c.addr = ca & ~32'h3; c.wdata = cd;
      pend.push_back(c);
    end
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1, 0);
  endtask

  // Randomized slave: 0-2 wait states, occasional two-cycle ERROR response.
  task automatic slave_policy(output bit hr, output bit hs);
    if (m_dp) begin
      if (!sl_started) begin
        sl_wait = $urandom_range(0, 2);
        sl_err = ($urandom_range(0, 5) == 0);
        sl_started = 1;
      end
      if (sl_wait > 0) begin
        hr = 0; hs = 0; sl_wait--;
      end else if (sl_err && !m_cancel) begin
        hr = 0; hs = 1;
      end else begin
        hr = 1; hs = sl_err; sl_started = 0;
      end
    end else begin
      hr = ($urandom_range(0, 3) != 0); hs = 0;
    end
  endtask

  initial begin
    int base;
    bit hr, hs;
    model_reset();
    repeat (2) @(negedge HCLK);
    chk("rst_HTRANS", 32'(HTRANS), 0);
    chk("rst_HADDR", HADDR, 0);
    chk("rst_HWRITE", 32'(HWRITE), 0);
    chk("rst_HWDATA", HWDATA, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("HSIZE", 32'(HSIZE), 32'h2);
    chk("HBURST", 32'(HBURST), 0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Single zero-wait write.
    base = n_rsp;
    cycle(1, 1, 32'h4, 32'hA5A5_0001, 1, 0);
    chk("t1_nonseq", 32'(HTRANS), 32'h2);
    cycle(0, 0, 0, 0, 1, 0);
    chk("t1_hwdata", HWDATA, 32'hA5A5_0001);
    idle(3);
    chk("t1_rsp_count", 32'(n_rsp - base), 1);

    // Read with two wait states.
    mem[32'h0] = 32'h0000_00FF;
    base = n_rsp;
    cycle(1, 0, 32'h0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    idle(3);
    chk("t2_rsp_count", 32'(n_rsp - base), 1);
    chk("t2_rdata", last_rdata, 32'h0000_00FF);

    // Fill the FIFO, refuse a fifth push, then drain back-to-back.
    base = n_rsp;
    for (int i = 0; i < 4; i++) cycle(1, i[0], 32'h40 + 32'(i * 4), 32'h1000 + 32'(i), 0, 0);
    chk("t3_full_ready", 32'(cmd_ready), 0);
    cycle(1, 1, 32'h80, 32'hFFFF_FFFF, 0, 0);
    idle(7);
    chk("t3_rsp_count", 32'(n_rsp - base), 4);
    chk("t3_last_rdata", last_rdata, 32'h0);

    // Two-cycle ERROR on a write cancels then re-presents the queued read.
    base = n_rsp;
    cycle(1, 1, 32'h10, 32'h1234_5678, 1, 0);
    cycle(1, 0, 32'h14, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1);
    chk("t4_cancel_idle", 32'(HTRANS), 0);
    cycle(0, 0, 0, 0, 1, 1);
    chk("t4_err_strobe", 32'(rsp_error), 1);
    chk("t4_reissue", 32'(HTRANS), 32'h2);
    idle(3);
    chk("t4_rsp_count", 32'(n_rsp - base), 2);

    // Error on the first cycle with HREADY=1: completion with error, no cancel.
    cycle(1, 0, 32'h18, 0, 1, 0);
    cycle(1, 1, 32'h1C, 32'h7777_0000, 1, 0);
    cycle(0, 0, 0, 0, 1, 1);
    idle(3);

    // Reset asserted during a waited data phase with two commands queued.
    cycle(1, 1, 32'h20, 32'hD1, 0, 0);
    cycle(1, 0, 32'h24, 0, 0, 0);
    cycle(1, 1, 32'h28, 32'hD3, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cmd_valid = 0; HREADY = 0; HRESP = 0;
    #2 HRESETn = 1'b0;
    #1;
    chk("t5_HTRANS", 32'(HTRANS), 0);
    chk("t5_HADDR", HADDR, 0);
    chk("t5_HWDATA", HWDATA, 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_cmd_ready", 32'(cmd_ready), 1);
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    model_reset();
    @(posedge HCLK);
    @(negedge HCLK);
    chk("t5_rsp_after", 32'(rsp_valid), 0);
    HRESETn = 1'b1;
    idle(3);

    // Read held by ten wait states while another command waits in the FIFO.
    base = n_rsp;
    cycle(1, 0, 32'h30, 0, 1, 0);
    cycle(1, 1, 32'h34, 32'hCAFE_0001, 1, 0);
    for (int i = 0; i < 10; i++) begin
      chk("t6_busy", 32'(busy), 1);
      cycle(0, 0, 0, 0, 0, 0);
    end
    chk("t6_no_rsp", 32'(n_rsp - base), 0);
    idle(4);
    chk("t6_rsp_count", 32'(n_rsp - base), 2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      slave_policy(hr, hs);
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 63)), $urandom, hr, hs);
    end
    for (int i = 0; i < 60 && (pend.size() != 0 || m_dp || rsp_due); i++) begin
      slave_policy(hr, hs);
      cycle(0, 0, 0, 0, hr, hs);
    end
    idle(2);
    chk("drain_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
